// File: rtl/decode_stage.sv
// RV32I decode pipeline stage: control/immediate generation, main + skid registers, flush.
// Optional illegal-encoding trap checking is built when DECODE_ILLEGAL_TRAP_EN is defined.
module decode_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_ins,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_imm,
    output logic            out_br,
    output logic            out_mem_to_reg,
    output logic            out_mem_write,
    output logic            out_alu_src,
    output logic            out_reg_write,
    output logic            out_pc_to_reg,
    output logic            out_alu_to_pc,
    output logic [2:0]      out_br_cond,
    output logic [3:0]      out_alu_op,
    output logic            out_a_is_pc,
    output logic            out_illegal
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_PASS = 4'd10;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic            br;
        logic            mem_to_reg;
        logic            mem_write;
        logic            alu_src;
        logic            reg_write;
        logic            pc_to_reg;
        logic            alu_to_pc;
        logic [2:0]      br_cond;
        logic [3:0]      alu_op;
        logic            a_is_pc;
        logic            illegal;
    } beat_t;

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r       = {XLEN{v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    // alt selects SUB for funct3 000 and SRA for funct3 101
    function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3, input logic alt);
        logic [3:0] op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            3'b111:  op = ALU_AND;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    logic [6:0] opcode_s;
    logic [2:0] funct3_s;
    logic [XLEN-1:0] imm_i_s, imm_s_s, imm_b_s, imm_j_s, imm_u_s;
    beat_t raw_s, dec_s, main_r, skid_r;
    logic main_valid_r, skid_valid_r, in_ready_r;
    logic main_valid_s, skid_valid_s;
    logic in_fire_s, out_fire_s;
    logic take_in_main_s, take_skid_main_s, take_in_skid_s;

    assign opcode_s = in_ins[6:0];
    assign funct3_s = in_ins[14:12];
    assign imm_i_s  = sext32({{20{in_ins[31]}}, in_ins[31:20]});
    assign imm_s_s  = sext32({{20{in_ins[31]}}, in_ins[31:25], in_ins[11:7]});
    assign imm_b_s  = sext32({{19{in_ins[31]}}, in_ins[31], in_ins[7], in_ins[30:25], in_ins[11:8], 1'b0});
    assign imm_j_s  = sext32({{11{in_ins[31]}}, in_ins[31], in_ins[19:12], in_ins[20], in_ins[30:21], 1'b0});
    assign imm_u_s  = sext32({in_ins[31:12], 12'b0});

    // Base decode of the incoming instruction word
    always_comb begin
        raw_s     = '0;
        raw_s.pc  = in_pc;
        raw_s.rs1 = in_ins[19:15];
        raw_s.rs2 = in_ins[24:20];
        raw_s.rd  = in_ins[11:7];
        case (opcode_s)
            OP_R: begin
                raw_s.reg_write = 1'b1;
                raw_s.alu_op    = alu_from_funct3(funct3_s, in_ins[30]);
            end
            OP_IMM: begin
                raw_s.alu_src   = 1'b1;
                raw_s.reg_write = 1'b1;
                raw_s.alu_op    = alu_from_funct3(funct3_s, (funct3_s == 3'b101) & in_ins[30]);
                raw_s.imm       = (funct3_s == 3'b001 || funct3_s == 3'b101)
                                  ? {{(XLEN-5){1'b0}}, in_ins[24:20]} : imm_i_s;
            end
            OP_LOAD: begin
                raw_s.alu_src    = 1'b1;
                raw_s.mem_to_reg = 1'b1;
                raw_s.reg_write  = 1'b1;
                raw_s.imm        = imm_i_s;
            end
            OP_STORE: begin
                raw_s.alu_src   = 1'b1;
                raw_s.mem_write = 1'b1;
                raw_s.imm       = imm_s_s;
            end
            OP_BRANCH: begin
                raw_s.br      = 1'b1;
                raw_s.br_cond = funct3_s;
                raw_s.imm     = imm_b_s;
                case (funct3_s[2:1])
                    2'b10:   raw_s.alu_op = ALU_SLT;
                    2'b11:   raw_s.alu_op = ALU_SLTU;
                    default: raw_s.alu_op = ALU_SUB;
                endcase
            end
            OP_JAL: begin
                raw_s.pc_to_reg = 1'b1;
                raw_s.reg_write = 1'b1;
                raw_s.a_is_pc   = 1'b1;
                raw_s.alu_src   = 1'b1;
                raw_s.imm       = imm_j_s;
            end
            OP_JALR: begin
                raw_s.alu_to_pc = 1'b1;
                raw_s.pc_to_reg = 1'b1;
                raw_s.reg_write = 1'b1;
                raw_s.alu_src   = 1'b1;
                raw_s.imm       = imm_i_s;
            end
            OP_LUI: begin
                raw_s.alu_src   = 1'b1;
                raw_s.reg_write = 1'b1;
                raw_s.alu_op    = ALU_PASS;
                raw_s.imm       = imm_u_s;
            end
            OP_AUIPC: begin
                raw_s.a_is_pc   = 1'b1;
                raw_s.alu_src   = 1'b1;
                raw_s.reg_write = 1'b1;
                raw_s.imm       = imm_u_s;
            end
            default: raw_s.alu_op = ALU_ADD;
        endcase
    end

`ifdef DECODE_ILLEGAL_TRAP_EN
    logic illegal_s;

    // Encoding validity check per opcode
    always_comb begin
        illegal_s = 1'b0;
        case (opcode_s)
            OP_R:      illegal_s = (in_ins[31:25] != 7'b0000000 && in_ins[31:25] != 7'b0100000) ||
                                   (in_ins[31:25] == 7'b0100000 && funct3_s != 3'b000 && funct3_s != 3'b101);
            OP_BRANCH: illegal_s = (funct3_s == 3'b010) || (funct3_s == 3'b011);
            OP_LOAD:   illegal_s = (funct3_s == 3'b011) || (funct3_s == 3'b110) || (funct3_s == 3'b111);
            OP_STORE:  illegal_s = (funct3_s > 3'b010);
            OP_JALR:   illegal_s = (funct3_s != 3'b000);
            OP_IMM, OP_JAL, OP_LUI, OP_AUIPC: illegal_s = 1'b0;
            default:   illegal_s = 1'b1;
        endcase
        illegal_s = illegal_s | (in_ins[1:0] != 2'b11);
    end

    // Suppress architectural side effects of an illegal instruction
    always_comb begin
        dec_s = raw_s;
        if (illegal_s) begin
            dec_s.illegal   = 1'b1;
            dec_s.reg_write = 1'b0;
            dec_s.mem_write = 1'b0;
            dec_s.br        = 1'b0;
            dec_s.alu_to_pc = 1'b0;
            dec_s.pc_to_reg = 1'b0;
        end else begin
            dec_s.illegal = 1'b0;
        end
    end
`else
    assign dec_s = raw_s;
`endif

    assign in_fire_s  = in_valid & in_ready_r;
    assign out_fire_s = main_valid_r & out_ready;

    // Main/skid occupancy and routing of the next beat
    always_comb begin
        main_valid_s     = main_valid_r;
        skid_valid_s     = skid_valid_r;
        take_in_main_s   = 1'b0;
        take_skid_main_s = 1'b0;
        take_in_skid_s   = 1'b0;
        if (flush) begin
            main_valid_s = 1'b0;
            skid_valid_s = 1'b0;
        end else if (skid_valid_r) begin
            if (out_fire_s) begin
                take_skid_main_s = 1'b1;
                skid_valid_s     = 1'b0;
                main_valid_s     = 1'b1;
            end else begin
                main_valid_s = main_valid_r;
            end
        end else if (in_fire_s) begin
            if (!main_valid_r || out_ready) begin
                take_in_main_s = 1'b1;
                main_valid_s   = 1'b1;
            end else begin
                take_in_skid_s = 1'b1;
                skid_valid_s   = 1'b1;
            end
        end else if (out_fire_s) begin
            main_valid_s = 1'b0;
        end else begin
            main_valid_s = main_valid_r;
        end
    end

    // Pipeline registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_r       <= '0;
            skid_r       <= '0;
            main_valid_r <= 1'b0;
            skid_valid_r <= 1'b0;
            in_ready_r   <= 1'b1;
        end else begin
            main_valid_r <= main_valid_s;
            skid_valid_r <= skid_valid_s;
            in_ready_r   <= ~skid_valid_s;
            if (take_in_main_s) begin
                main_r <= dec_s;
            end else if (take_skid_main_s) begin
                main_r <= skid_r;
            end
            if (take_in_skid_s) begin
                skid_r <= dec_s;
            end
        end
    end

    assign in_ready       = in_ready_r;
    assign out_valid      = main_valid_r;
    assign out_pc         = main_r.pc;
    assign out_rs1        = main_r.rs1;
    assign out_rs2        = main_r.rs2;
    assign out_rd         = main_r.rd;
    assign out_imm        = main_r.imm;
    assign out_br         = main_r.br;
    assign out_mem_to_reg = main_r.mem_to_reg;
    assign out_mem_write  = main_r.mem_write;
    assign out_alu_src    = main_r.alu_src;
    assign out_reg_write  = main_r.reg_write;
    assign out_pc_to_reg  = main_r.pc_to_reg;
    assign out_alu_to_pc  = main_r.alu_to_pc;
    assign out_br_cond    = main_r.br_cond;
    assign out_alu_op     = main_r.alu_op;
    assign out_a_is_pc    = main_r.a_is_pc;
    assign out_illegal    = main_r.illegal;
endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised instruction-decode stage for the processor core. It combines control-signal generation and immediate generation for the full RV32I base opcode set, including LUI and AUIPC, with immediates sign-extended to XLEN. It sits between fetch and execute as a pipeline stage with valid/ready handshakes on both sides and a two-entry skid buffer. A synchronous flush supports branch redirect.

## Interface
- XLEN, default 32: datapath width (32 or 64); immediate and PC width.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  drop all buffered beats; synchronous.
- in_valid  in  1  fetch beat valid.
- in_ready  out  1  stage can accept a beat.
- in_ins  in  32  instruction word.
- in_pc  in  XLEN  instruction address.
- out_valid  out  1  decoded beat valid.
- out_ready  in  1  execute accepts the beat.
- out_pc  out  XLEN  PC of the decoded instruction.
- out_rs1, out_rs2, out_rd  out  5 each  register fields ins[19:15], [24:20], [11:7].
- out_imm  out  XLEN  sign-extended immediate.
- out_br, out_mem_to_reg, out_mem_write, out_alu_src, out_reg_write, out_pc_to_reg, out_alu_to_pc  out  1 each  control flags.
- out_br_cond  out  3  funct3 for branches, 0 otherwise.
- out_alu_op  out  4  ALU opcode: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASS_B.
- out_a_is_pc  out  1  ALU A operand is PC (AUIPC, JAL).
- out_illegal  out  1  unrecognised encoding (see Configuration).

## Operation
- Decode is combinational on the incoming beat and is captured into the output register, so all out_* fields are registered.
- R-type (0110011): reg_write; alu_op from funct3 plus funct7[5] (ADD/SUB, SRL/SRA); imm 0.
- I-ALU (0010011): alu_src, reg_write; I-imm. SRAI is selected when ins[30]=1; the shift imm is ins[24:20], zero-extended.
- Load (0000011): alu_src, mem_to_reg, reg_write, ADD; I-imm.
- Store (0100011): alu_src, mem_write, ADD; S-imm.
- Branch (1100011): br, br_cond=funct3; B-imm.
  - BEQ/BNE use SUB.
  - BLT/BGE use SLT.
  - BLTU/BGEU use SLTU.
- JAL (1101111): pc_to_reg, reg_write, a_is_pc, alu_src, ADD; J-imm.
- JALR (1100111): alu_to_pc, pc_to_reg, reg_write, alu_src, ADD; I-imm.
- LUI (0110111): alu_src, reg_write, PASS_B; U-imm (ins[31:12]<<12).
- AUIPC (0010111): a_is_pc, alu_src, reg_write, ADD; U-imm.
- All immediates are sign-extended from ins[31] to XLEN. For XLEN=64, the U-imm is also sign-extended above bit 31.
- Any other opcode produces all control flags 0 and imm 0.

## Timing
- Reset: out_valid=0, in_ready=1, every other output 0, both entries empty.
- Latency: a beat accepted at edge N is presented on out_* after edge N (valid in cycle N+1).
- Transfers:
  - Input transfer happens when in_valid&in_ready.
  - Output transfer happens when out_valid&out_ready.
- Storage is a main (output) register plus a skid register.
  - in_ready is registered and equals "skid empty".
  - Accepted beat, main empty or draining this cycle: the beat goes to main.
  - Accepted beat, main held (out_valid&!out_ready): the beat goes to skid; in_ready drops next cycle.
  - Skid full and main drains: skid moves to main; in_ready rises next cycle.
- Full throughput: one beat per cycle whenever out_ready stays 1.
- Output stability: out_* stays stable while out_valid&!out_ready.
- Flush has highest priority.
  - Both entries are cleared at the edge, so out_valid=0 and in_ready=1 next cycle.
  - An input beat presented in the flush cycle is discarded.
  - An output transfer in the flush cycle still counts as completed.
- rst_n asserted mid-stream: asynchronous return to reset values; beats in flight are lost.

## Configuration
- DECODE_ILLEGAL_TRAP_EN defined: out_illegal=1 for any of:
  - an unlisted opcode;
  - ins[1:0]!=2'b11;
  - an invalid funct3/funct7 combination (R-type funct7 not 0000000/0100000, SUB/SRA pattern on other funct3, branch funct3 010/011, load funct3 011/110/111, store funct3 >010, JALR funct3!=000).
  - Whenever out_illegal=1, reg_write, mem_write, br, alu_to_pc and pc_to_reg are forced to 0.
- DECODE_ILLEGAL_TRAP_EN undefined: out_illegal is tied 0 and no checking logic is built. Unlisted opcodes still decode to all-zero controls; invalid funct fields decode by funct3 alone.

## Test plan
- XLEN=32 stream, out_ready=1. Each listed word must produce the listed outputs, one beat per cycle, in order:
  - 00b00533 -> reg_write=1, alu_src=0, alu_op=0, imm=0, rd=10.
  - 02000513 -> alu_src=1, imm=32.
  - 0005a503 -> mem_to_reg=1, imm=0.
  - 00a5a023 -> mem_write=1, reg_write=0.
  - 00b50263 -> br=1, br_cond=0, alu_op=1, imm=4.
  - fedff0ef -> pc_to_reg=1, imm=FFFFFFEC.
  - 004580e7 -> alu_to_pc=1, imm=4.
- XLEN=64: fedff0ef -> imm=FFFFFFFFFFFFFFEC; 800002b7 (LUI) -> imm=FFFFFFFF80000000, alu_op=10.
- Backpressure: out_ready=0 while 3 beats are offered. Required response:
  - main holds beat 0 unchanged;
  - skid takes beat 1;
  - in_ready=0 from the next cycle;
  - raising out_ready yields beats 0, 1, 2 with no loss or duplication.
- Flush with both entries full and in_valid=1 -> out_valid=0 and in_ready=1 next cycle; the offered beat never appears.
- With DECODE_ILLEGAL_TRAP_EN: 00000000 -> illegal=1, all writes 0; 02b54533 (funct7 0000001) -> illegal=1. Without it: illegal stays 0.
- rst_n pulsed low mid-backpressure -> out_valid=0 and in_ready=1 immediately, without waiting for an edge.
